// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory responder for the MEM-stage port.
// Accepts one load/store over a valid/ready request handshake, waits
// WAIT_STATES cycles, then answers over a valid/ready response handshake.
//
// Parameters:
//   ADDR_WIDTH  - word-address width, depth = 2^ADDR_WIDTH 32-bit words
//   WAIT_STATES - cycles between acceptance and response (0..15)
//
// Ports:
//   clk, rst (sync, active-high)
//   req_valid/req_ready/req_write/req_addr/req_wdata/req_be  - request side
//   resp_valid/resp_ready/resp_rdata/resp_err                - response side
//
// Optional feature: define DMEM_ERR_CHECK_EN to flag misaligned or
// out-of-range addresses with resp_err (no write is performed for them).
// Without it, resp_err is 0, addr[1:0] is ignored and addresses wrap.

module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [3:0] cnt;
    logic [3:0] cnt_nx;

    // Latched request
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic                  err_q;

    // Response registers
    logic [31:0] rdata_q;
`ifdef DMEM_ERR_CHECK_EN
    logic        rerr_q;
`endif

    logic [31:0] mem [DEPTH];

    // Request-side decode
    logic                  accept;
    logic                  req_err;
    logic [ADDR_WIDTH-1:0] req_idx;

    // Access-edge operands: live inputs when the access coincides with
    // acceptance (WAIT_STATES == 0), otherwise the latched request.
    logic                  access;
    logic                  acc_wr;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_be;
    logic                  acc_err;
    logic                  mem_we;
    logic                  done;

    assign req_idx = req_addr[ADDR_WIDTH+1:2];

`ifdef DMEM_ERR_CHECK_EN
    assign req_err = (req_addr[1:0] != 2'b00)
                   || ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
`else
    logic addr_unused;
    assign addr_unused = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};
    assign req_err     = 1'b0;
`endif

    assign accept = req_valid && (state == IDLE);
    assign done   = (state == RESP) && resp_ready;

    always_comb begin
        access = 1'b0;
        if (state == IDLE) begin
            access = accept && (WAIT_STATES == 0);
        end else if (state == WAIT) begin
            access = (cnt <= 4'd1);
        end
    end

    always_comb begin
        if (state == IDLE) begin
            acc_wr    = req_write;
            acc_idx   = req_idx;
            acc_wdata = req_wdata;
            acc_be    = req_be;
            acc_err   = req_err;
        end else begin
            acc_wr    = wr_q;
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
            acc_err   = err_q;
        end
    end

    // Reset wins over the access edge, so a store pending in WAIT is dropped.
    assign mem_we = !rst && access && acc_wr && !acc_err;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nx = RESP;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // Request capture
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            wr_q    <= req_write;
            idx_q   <= req_idx;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            err_q   <= req_err;
        end
    end

    // Response data: loaded on the access edge, cleared on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else if (access) begin
            if (acc_wr || acc_err) begin
                rdata_q <= 32'd0;
            end else begin
                rdata_q <= mem[acc_idx];
            end
        end else if (done) begin
            rdata_q <= 32'd0;
        end
    end

`ifdef DMEM_ERR_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rerr_q <= 1'b0;
        end else if (access) begin
            rerr_q <= acc_err;
        end else if (done) begin
            rerr_q <= 1'b0;
        end
    end
`endif

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Outputs
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_rdata = rdata_q;
`ifdef DMEM_ERR_CHECK_EN
        resp_err   = rerr_q;
`else
        resp_err   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder.
// Three instances with WAIT_STATES = 2, 0 and 4 share one clock.

module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic [3:0]  req_be     [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .ADDR_WIDTH (10),
            .WAIT_STATES((g == 0) ? 2 : (g == 1) ? 0 : 4)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g])
        );
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mdl [3][1024];
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic int ws_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 0 : 4;
    endfunction

    function automatic logic err_of(input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
        return (a[1:0] != 2'b00) || ((a >> 12) != 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction; stall = cycles resp_ready is held low
    task automatic xact(input int d, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int stall, output logic [31:0] got);
        exp_t e;
        int   idx;
        int   cnt;
        idx = int'((a >> 2) & 32'h3ff);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_be[d]    = be;
        e.err   = err_of(a);
        e.rdata = 32'd0;
        if (!e.err) begin
            if (wr) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) mdl[d][idx][8*i +: 8] = wd[8*i +: 8];
            end else begin
                e.rdata = mdl[d][idx];
            end
        end
        sb.push_back(e);
        @(negedge clk);
        req_valid[d] = 1'b0;
        cnt = 0;
        while (!resp_valid[d] && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("latency", 32'(cnt), 32'(ws_of(d)));
        for (int s = 0; s < stall; s++) begin
            chk("bp_valid", 32'(resp_valid[d]), 32'd1);
            chk("bp_ready", 32'(req_ready[d]), 32'd0);
            chk("bp_rdata", resp_rdata[d], e.rdata);
            if (s == 1) begin
                req_valid[d] = 1'b1;
                req_write[d] = 1'b1;
                req_addr[d]  = a;
                req_wdata[d] = 32'h5a5a5a5a;
                req_be[d]    = 4'hf;
            end
            @(negedge clk);
        end
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("resp_valid", 32'(resp_valid[d]), 32'd1);
            chk("hs_req_ready", 32'(req_ready[d]), 32'd0);
            chk("resp_rdata", resp_rdata[d], e.rdata);
            chk("resp_err", 32'(resp_err[d]), 32'(e.err));
        end
        got = resp_rdata[d];
        @(negedge clk);
        resp_ready[d] = 1'b0;
        chk("post_valid", 32'(resp_valid[d]), 32'd0);
        chk("post_rdata", resp_rdata[d], 32'd0);
        chk("post_err", 32'(resp_err[d]), 32'd0);
        chk("post_ready", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] addrs [8];

        for (int i = 0; i < 3; i++) begin
            rst[i]        = 1'b1;
            req_valid[i]  = 1'b0;
            req_write[i]  = 1'b0;
            req_addr[i]   = 32'd0;
            req_wdata[i]  = 32'd0;
            req_be[i]     = 4'd0;
            resp_ready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_req_ready", 32'(req_ready[i]), 32'd1);
            chk("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
            chk("rst_resp_rdata", resp_rdata[i], 32'd0);
            chk("rst_resp_err", 32'(resp_err[i]), 32'd0);
            rst[i] = 1'b0;
        end

        // WAIT_STATES = 2: store then load
        xact(0, 1'b1, 32'h10, 32'hdeadbeef, 4'hf, 0, got);
        chk("store_rdata", got, 32'd0);
        xact(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, got);
        chk("load_deadbeef", got, 32'hdeadbeef);

        // Byte lanes
        xact(0, 1'b1, 32'h20, 32'h11223344, 4'hf, 0, got);
        xact(0, 1'b1, 32'h20, 32'haabbccdd, 4'b0101, 0, got);
        xact(0, 1'b0, 32'h20, 32'd0, 4'h0, 0, got);
        chk("byte_lanes", got, 32'h11bb33dd);

        // Back-pressure with an ignored request pulse
        xact(0, 1'b0, 32'h10, 32'd0, 4'h0, 5, got);
        chk("bp_load", got, 32'hdeadbeef);
        xact(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, got);
        chk("bp_no_write", got, 32'hdeadbeef);

        // Zero byte enables change nothing
        xact(0, 1'b1, 32'h10, 32'h0badf00d, 4'h0, 0, got);
        xact(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, got);
        chk("be_zero", got, 32'hdeadbeef);

`ifdef DMEM_ERR_CHECK_EN
        xact(0, 1'b1, 32'h40, 32'h01020304, 4'hf, 0, got);
        xact(0, 1'b1, 32'h42, 32'hffffffff, 4'hf, 0, got);
        xact(0, 1'b1, 32'h1040, 32'hffffffff, 4'hf, 0, got);
        xact(0, 1'b0, 32'h40, 32'd0, 4'h0, 0, got);
        chk("err_no_write", got, 32'h01020304);
`else
        xact(0, 1'b1, 32'h1004, 32'hcafef00d, 4'hf, 0, got);
        xact(0, 1'b0, 32'h4, 32'd0, 4'h0, 0, got);
        chk("wrap", got, 32'hcafef00d);
`endif

        // WAIT_STATES = 0: random stores then read-back
        for (int i = 0; i < 8; i++) begin
            addrs[i] = {20'd0, 4'(i), 6'($urandom_range(0, 63)), 2'b00};
            d        = $urandom;
            xact(1, 1'b1, addrs[i], d, 4'hf, 0, got);
        end
        for (int i = 0; i < 8; i++) begin
            xact(1, 1'b0, addrs[i], 32'd0, 4'h0, i % 2, got);
        end

        // WAIT_STATES = 4: reset during WAIT discards the store
        xact(2, 1'b1, 32'h40, 32'd0, 4'hf, 0, got);
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 32'h40;
        req_wdata[2] = 32'h12345678;
        req_be[2]    = 4'hf;
        @(negedge clk);
        req_valid[2] = 1'b0;
        chk("wait_ready", 32'(req_ready[2]), 32'd0);
        @(negedge clk);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        chk("mid_rst_ready", 32'(req_ready[2]), 32'd1);
        chk("mid_rst_valid", 32'(resp_valid[2]), 32'd0);
        chk("mid_rst_rdata", resp_rdata[2], 32'd0);
        chk("mid_rst_err", 32'(resp_err[2]), 32'd0);
        a = 32'h40;
        xact(2, 1'b0, a, 32'd0, 4'h0, 0, got);
        chk("rst_discard", got, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
